// File: rtl/periph_pkg.sv
// Shared register offsets, bit positions and types for the peripheral register responder.
package periph_pkg;

  localparam int unsigned REQ_ADDR_W = 16;

  localparam logic [REQ_ADDR_W-1:0] REG_ID      = 16'h0000;
  localparam logic [REQ_ADDR_W-1:0] REG_SCRATCH = 16'h0004;
  localparam logic [REQ_ADDR_W-1:0] REG_CTRL    = 16'h0008;
  localparam logic [REQ_ADDR_W-1:0] REG_COUNT   = 16'h000C;
  localparam logic [REQ_ADDR_W-1:0] REG_STATUS  = 16'h0010;

  localparam int unsigned CTRL_CNT_EN_BIT  = 0;
  localparam int unsigned CTRL_CNT_CLR_BIT = 1;
  localparam int unsigned STATUS_OVF_BIT   = 0;
  localparam int unsigned STATUS_ERR_BIT   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } periph_req_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/periph_event_counter.sv
// Free-running 32-bit event counter; clear has priority over increment, o_wrap flags the
// edge on which the count rolls over to zero.
module periph_event_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_clr,
  output logic [31:0] o_count,
  output logic        o_wrap
);

  logic [31:0] r_count;

  // Count register: clear beats increment on a coincident edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 32'd0;
    end else if (i_clr) begin
      r_count <= 32'd0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = i_en && !i_clr && (r_count == 32'hFFFF_FFFF);

endmodule

// File: rtl/periph_reg_responder.sv
// Peripheral bus target: one request at a time, fixed wait states, then a held response
// from a small register file (ID, scratch, control, event counter, sticky status).
module periph_reg_responder
  import periph_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 32,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cnt_overflow
);

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_nxt;
  logic        w_enter_resp;
  periph_req_t r_req, w_acc;

  logic [31:0] r_scratch;
  logic        r_cnt_en, r_st_ovf, r_st_err;
  logic        r_req_ready, r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [31:0] w_count, w_rdata;
  logic        w_cnt_wrap, w_dec_err, w_wr, w_wr_scratch, w_wr_ctrl, w_wr_status, w_cnt_clr;

  // Next-state logic; the register access happens on the single edge that enters RESP.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_wait_nxt  = WAIT_INIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = 4'd0;
      end
    endcase
  end

  // With zero wait states the access uses the live request, otherwise the latched copy.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc = '{write: req_write, addr: REQ_ADDR_W'(req_addr), wdata: req_wdata, wstrb: req_wstrb};
    end else begin
      w_acc = r_req;
    end
  end

  assign w_dec_err    = (w_acc.addr[1:0] != 2'b00) || (w_acc.addr > REG_STATUS);
  assign w_wr         = w_enter_resp && w_acc.write && !w_dec_err;
  assign w_wr_scratch = w_wr && (w_acc.addr == REG_SCRATCH);
  assign w_wr_ctrl    = w_wr && (w_acc.addr == REG_CTRL) && w_acc.wstrb[0];
  assign w_wr_status  = w_wr && (w_acc.addr == REG_STATUS) && w_acc.wstrb[0];
  assign w_cnt_clr    = w_wr_ctrl && w_acc.wdata[CTRL_CNT_CLR_BIT];

  // Read mux; COUNT returns the value held before this edge's update.
  always_comb begin
    w_rdata = 32'd0;
    case (w_acc.addr)
      REG_ID:      w_rdata = ID_VALUE;
      REG_SCRATCH: w_rdata = r_scratch;
      REG_CTRL:    w_rdata = {31'd0, r_cnt_en};
      REG_COUNT:   w_rdata = w_count;
      REG_STATUS:  w_rdata = {30'd0, r_st_err, r_st_ovf};
      default:     w_rdata = 32'd0;
    endcase
  end

  periph_event_counter u_counter (
    .clk     (clk),
    .reset   (reset),
    .i_en    (r_cnt_en),
    .i_clr   (w_cnt_clr),
    .o_count (w_count),
    .o_wrap  (w_cnt_wrap)
  );

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Request capture at the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req <= '0;
    end else if ((r_state == IDLE) && req_valid) begin
      r_req <= w_acc;
    end
  end

  // Register file; a sticky bit being set wins over a write-1-to-clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch <= 32'd0;
      r_cnt_en  <= 1'b0;
      r_st_ovf  <= 1'b0;
      r_st_err  <= 1'b0;
    end else begin
      if (w_wr_scratch) begin
        r_scratch <= apply_wstrb(r_scratch, w_acc.wdata, w_acc.wstrb);
      end
      if (w_wr_ctrl) begin
        r_cnt_en <= w_acc.wdata[CTRL_CNT_EN_BIT];
      end
      if (w_cnt_wrap) begin
        r_st_ovf <= 1'b1;
      end else if (w_wr_status && w_acc.wdata[STATUS_OVF_BIT]) begin
        r_st_ovf <= 1'b0;
      end
      if (w_enter_resp && w_dec_err) begin
        r_st_err <= 1'b1;
      end else if (w_wr_status && w_acc.wdata[STATUS_ERR_BIT]) begin
        r_st_err <= 1'b0;
      end
    end
  end

  // Handshake outputs: response held until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (w_dec_err || w_acc.write) ? 32'd0 : w_rdata;
      r_rsp_err   <= w_dec_err;
    end else if ((r_state == IDLE) && req_valid) begin
      r_req_ready <= 1'b0;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign cnt_overflow = r_st_ovf;

endmodule

// File: tb/tb_periph_reg_responder.sv
// Scoreboard bench: expected responses are queued at issue from a behavioural register
// model and checked by an independent monitor whenever a response is consumed.
module tb_periph_reg_responder;

  localparam int          WS  = 2;
  localparam logic [31:0] IDV = 32'hC0DE_0001;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, cnt_overflow;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;

  always #5 clk = ~clk;

  periph_reg_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(WS), .ID_VALUE(IDV)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cnt_overflow(cnt_overflow)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   in_rsp = 1'b0;

  // Behavioural model of the register file
  logic [31:0] m_scratch = 32'd0, m_count = 32'd0;
  logic        m_en = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
  bit          acc_pend = 1'b0, acc_wr = 1'b0;
  logic [7:0]  acc_addr = 8'd0;
  logic [31:0] acc_wd = 32'd0;
  logic [3:0]  acc_ws = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit bad_addr(input logic [7:0] a);
    return (a[1:0] != 2'b00) || (a > 8'h10);
  endfunction

  // One clock edge of the model: pending access, then counter rules.
  task automatic model_edge();
    logic [31:0] n_count;
    logic        n_en, n_ovf, n_err;
    bit          clr;
    if (reset) begin
      m_scratch = 32'd0; m_count = 32'd0; m_en = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      acc_pend = 1'b0;
    end else begin
      n_en = m_en; n_ovf = m_ovf; n_err = m_err; clr = 1'b0;
      if (acc_pend) begin
        if (bad_addr(acc_addr)) begin
          n_err = 1'b1;
        end else if (acc_wr) begin
          if (acc_addr == 8'h04) begin
            for (int b = 0; b < 4; b++) if (acc_ws[b]) m_scratch[8*b +: 8] = acc_wd[8*b +: 8];
          end else if (acc_addr == 8'h08 && acc_ws[0]) begin
            n_en = acc_wd[0];
            clr  = acc_wd[1];
          end else if (acc_addr == 8'h10 && acc_ws[0]) begin
            if (acc_wd[0]) n_ovf = 1'b0;
            if (acc_wd[1]) n_err = 1'b0;
          end
        end
        acc_pend = 1'b0;
      end
      if (clr) n_count = 32'd0;
      else if (m_en) begin
        n_count = m_count + 32'd1;
        if (m_count == 32'hFFFF_FFFF) n_ovf = 1'b1;
      end else n_count = m_count;
      m_count = n_count; m_en = n_en; m_ovf = n_ovf; m_err = n_err;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Issue one transaction; expected response is pushed before the handshake edge.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int hold);
    exp_t        e;
    logic [32:0] proj;
    proj    = {1'b0, m_count} + (m_en ? 33'(WS) : 33'd0);
    e.err   = bad_addr(a);
    e.rdata = 32'd0;
    e.hs_cyc = cyc;
    if (!e.err && !wr) begin
      case (a)
        8'h00:   e.rdata = IDV;
        8'h04:   e.rdata = m_scratch;
        8'h08:   e.rdata = {31'd0, m_en};
        8'h0C:   e.rdata = proj[31:0];
        8'h10:   e.rdata = {30'd0, m_err, m_ovf | (m_en & proj[32])};
        default: e.rdata = 32'd0;
      endcase
    end
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
    rsp_ready = (hold == 0);
    acc_wr = wr; acc_addr = a; acc_wd = wd; acc_ws = ws; acc_pend = (WS == 0);
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom);
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    for (int i = 1; i <= WS; i++) begin
      if (i == WS) acc_pend = 1'b1;
      tick();
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, e.rdata);
      chk("hold_err", 32'(rsp_err), 32'(e.err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  // Monitor: latency on the rising response, data/err on consumption, overflow level each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_rsp = 1'b0;
    end else begin
      chk("cnt_overflow", 32'(cnt_overflow), 32'(m_ovf));
      if (rsp_valid && !in_rsp) begin
        in_rsp = 1'b1;
        chk("exp_queue_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) chk("latency", 32'(cyc - exp_q[0].hs_cyc), 32'(WS + 1));
      end
      if (rsp_valid && rsp_ready) begin
        in_rsp = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned sel;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'd0;
    req_wdata = 32'd0; req_wstrb = 4'd0; rsp_ready = 1'b0;
    tick(); tick();
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_cnt_overflow", 32'(cnt_overflow), 32'd0);
    reset = 1'b0;
    tick();

    xfer(1'b0, 8'h00, 32'd0, 4'd0, 0);
    xfer(1'b1, 8'h04, 32'hAABBCCDD, 4'b0101, 0);
    xfer(1'b0, 8'h04, 32'd0, 4'd0, 0);
    xfer(1'b1, 8'h04, 32'h11223344, 4'b1111, 0);
    xfer(1'b0, 8'h04, 32'd0, 4'd0, 5);
    xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 0);
    xfer(1'b0, 8'h00, 32'd0, 4'd0, 0);

    xfer(1'b0, 8'h06, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h10, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h20, 32'd0, 4'd0, 1);
    xfer(1'b0, 8'h10, 32'd0, 4'd0, 0);
    xfer(1'b1, 8'h10, 32'h2, 4'hF, 0);
    xfer(1'b0, 8'h10, 32'd0, 4'd0, 0);

    // Counter wrap: preload near the top while stopped, then run through it.
    xfer(1'b1, 8'h08, 32'h0, 4'hF, 0);
    force dut.u_counter.r_count = 32'hFFFF_FFF0;
    m_count = 32'hFFFF_FFF0;
    tick();
    release dut.u_counter.r_count;
    xfer(1'b1, 8'h08, 32'h1, 4'hF, 0);
    for (int i = 0; i < 20; i++) tick();
    xfer(1'b0, 8'h0C, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h10, 32'd0, 4'd0, 0);
    xfer(1'b1, 8'h08, 32'h3, 4'hF, 0);
    xfer(1'b0, 8'h0C, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h08, 32'd0, 4'd0, 0);
    xfer(1'b1, 8'h10, 32'h1, 4'hF, 0);
    xfer(1'b0, 8'h10, 32'd0, 4'd0, 0);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(7, 0);
      xfer(1'($urandom), (sel <= 4) ? 8'(sel * 4) : 8'($urandom), $urandom, 4'($urandom),
           int'($urandom_range(2, 0)));
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) tick();
    end

    // Reset while waiting: the pending response must vanish.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    xfer(1'b0, 8'h00, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h04, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h08, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h0C, 32'd0, 4'd0, 0);
    xfer(1'b0, 8'h10, 32'd0, 4'd0, 0);

    tick(); tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/periph_reg_responder.md
Name: periph_reg_responder

Overview:
- Memory-mapped bus responder (target side) for the core's peripheral request/response interface.
- Accepts one read/write request at a time, inserts a parameterised number of wait states, then returns a response.
- Contains a small register file: ID, scratch, control, free-running event counter and sticky status.
- Instanced inside the peripheral subsystem on core_clk, facing the core's load/store initiator.

Parameters:
- ADDR_W, 8, request address width in bits (byte address)
- DATA_W, 32, data width; fixed at 32 for this revision
- WAIT_STATES, 2, cycles between request accept and rsp_valid, minus 1; legal range 0..15
- ID_VALUE, 32'hC0DE_0001, read-only value at the ID register

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables for writes
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator consumes the response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode or alignment error
- cnt_overflow  out  1  level copy of STATUS.ovf, for the interrupt controller

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt_overflow=0.
  - SCRATCH=0, CTRL=0, COUNT=0, STATUS=0.
  - FSM=IDLE, wait counter=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid is seen, latch write/addr/wdata/wstrb and set req_ready=0.
  - If WAIT_STATES=0, go to RESP. Otherwise go to WAIT with wait counter = WAIT_STATES-1.
- WAIT:
  - Decrement the wait counter each cycle; go to RESP when it reaches 0.
- Entering RESP (single edge):
  - Perform the register access.
  - Drive rsp_valid=1 together with rsp_rdata and rsp_err.
- Latency:
  - Request handshake at cycle T gives rsp_valid high from T+1+WAIT_STATES.
  - With WAIT_STATES=0, rsp_valid is high at T+1.
- RESP:
  - Hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready is seen.
  - On that cycle, return to IDLE with rsp_valid=0 and req_ready=1.
  - Back-to-back throughput is 1 transaction per 2+WAIT_STATES cycles.
- Register map (byte offsets):
  - 0x00 ID: read-only, ID_VALUE.
  - 0x04 SCRATCH: read/write, byte-strobed.
  - 0x08 CTRL: bit0 cnt_en (read/write). bit1 cnt_clr, write 1 to pulse, reads as 0. Other bits read 0.
  - 0x0C COUNT: read-only, 32-bit.
  - 0x10 STATUS: bit0 ovf (write-1-to-clear), bit1 err (write-1-to-clear).
- Read-only targets: writes complete with rsp_err=0 and no effect.
- Errors:
  - Trigger: req_addr[1:0]!=0, or offset >0x10.
  - Result: rsp_err=1, rsp_rdata=0, no register changed, STATUS.err set.
- Write strobes: req_wstrb applies per byte to SCRATCH, CTRL and STATUS.
- COUNT behaviour:
  - Increments by 1 each cycle while cnt_en=1.
  - 32'hFFFF_FFFF+1 wraps to 0 and sets STATUS.ovf.
- Simultaneous events:
  - cnt_clr write and increment on the same edge: clear wins (COUNT=0).
  - ovf set and W1C on the same edge: set wins.
  - err set by the current access and a W1C of err by the same access cannot coincide, because error accesses write nothing.
- Read of COUNT returns the value before that edge's update.
- Reset mid-transaction: the pending response is dropped and the FSM returns to IDLE next cycle. The initiator is reset by the same signal.
- Accesses in IDLE with req_valid=0 have no effect. req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package periph_pkg:
  - Offsets REG_ID, REG_SCRATCH, REG_CTRL, REG_COUNT, REG_STATUS.
  - CTRL and STATUS bit indices.
  - resp_state_t enum {IDLE, WAIT, RESP}.
  - Request struct periph_req_t {write, addr, wdata, wstrb}.
- Sub-module periph_event_counter: 32-bit counter with en, clr and an overflow pulse output; the responder owns the STATUS sticky bit.

Test Plan:
- Reset, then read 0x00 with WAIT_STATES=2: rsp_valid rises 3 cycles after the handshake; rsp_rdata=32'hC0DE_0001, rsp_err=0.
- Write 0x04 with 32'hAABBCCDD, wstrb=4'b0101; read back gives 32'h00BB00DD. A second write of 32'h11223344 with wstrb=4'b1111 reads back 32'h11223344.
- Hold rsp_ready=0 for 5 cycles: rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout. Asserting rsp_ready returns req_ready=1 on the next cycle.
- Read 0x06 and read 0x20: each gives rsp_err=1, rsp_rdata=0 and STATUS reads 32'h2. Writing STATUS with 32'h2 clears it to 0.
- Set cnt_en; force COUNT near wrap (clr, then run from 32'hFFFF_FFF0 via a backdoor): after wrap, COUNT is small, STATUS.ovf=1 and cnt_overflow=1. Writing CTRL with 32'h3 gives COUNT=0 on that edge while counting continues.
- Assert reset while in WAIT: next cycle rsp_valid=0, req_ready=1, all registers at reset values, and a new read of 0x00 completes normally.
